if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage feeding if_id. Owns the PC and runs a req/ack/rvalid
//  transaction on the instruction bus. Presents {if_pc, if_inst} to if_id and
//  raises stallreq_if to the ctrl unit until a fetched instruction is held.
//  Applies branch redirects from ID and exception redirects (flush/new_pc) from ctrl.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  PC fetched first after reset
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous, active-high reset
//  stall           in   6   ctrl stall vector; stall[0] = hold PC/IF
//  flush           in   1   exception flush; redirect to new_pc
//  new_pc          in   32  exception handler address (valid with flush)
//  branch_flag_i   in   1   ID resolved taken branch/jump (1-cycle pulse)
//  branch_target_i in   32  branch target (valid with branch_flag_i)
//  inst_req        out  1   bus request
//  inst_addr       out  32  bus address (stable while inst_req)
//  inst_ack        in   1   address accepted this cycle
//  inst_rvalid     in   1   read data valid this cycle
//  inst_rdata      in   32  read data
//  if_pc           out  32  PC of held instruction
//  if_inst         out  32  held instruction; 0 when none held
//  stallreq_if     out  1   no valid instruction held
// BEHAVIOUR
//  Reset: state IDLE, pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, if_pc=RESET_PC,
//   if_inst=0, inst_valid=0, pend_br=0, stallreq_if=1. Reset mid-transaction
//   drops everything; the bus shares rst.
//  States: IDLE, REQ, WAIT, HOLD, DRAIN. All outputs registered.
//   IDLE : next cycle -> REQ (inst_req=1, inst_addr=pc).
//   REQ  : inst_req held, addr stable, never withdrawn before inst_ack;
//          ack -> WAIT, req=0.
//   WAIT : rvalid -> HOLD; if_inst<=inst_rdata, if_pc<=pc, inst_valid=1.
//   HOLD : while stall[0]=1 hold if_pc/if_inst. stall[0]=0 -> consumed:
//          pc<=next_pc, inst_valid=0, if_inst<=0, -> REQ with new addr.
//   DRAIN: in-flight data is discarded on rvalid, then -> REQ with pc.
//  stallreq_if = ~inst_valid (1 in IDLE/REQ/WAIT/DRAIN, 0 in HOLD).
//  Min latency: req at cycle t, ack t, rvalid t+1 -> if_inst valid t+2; 3 cycles/inst.
//  next_pc = pend_br ? pend_target : pc+4 (32-bit, wraps at 2^32, no carry out).
//  Branch: branch_flag_i in any state latches pend_br=1, pend_target; consumed and
//   cleared at the next HOLD consumption (delay slot = instruction already fetched).
//   Same-cycle branch_flag_i and consumption uses branch_target_i directly.
//  Flush (highest priority, any state incl. stall[0]=1): pc<=new_pc, inst_valid=0,
//   if_inst<=0, pend_br=0.
//   IDLE/HOLD -> REQ. WAIT -> DRAIN. REQ -> stays REQ with old addr until ack,
//   then DRAIN. DRAIN -> stays DRAIN.
//   Flush and rvalid in the same cycle: data dropped, -> REQ.
//   Flush overrides a same-cycle branch_flag_i.
//  PC low bits are not checked; addresses are forwarded as-is.
// TESTING
//  1 rst 3 cycles, bus ack same cycle, rvalid +1 -> first inst_addr=BFC00000;
//    if_pc=BFC00000, if_inst=rdata, stallreq_if=0 two cycles after req.
//  2 Free-running, stall=0 -> addresses BFC00000,BFC00004,BFC00008; one inst per 3 cycles.
//  3 Hold HOLD with stall[0]=1 for 5 cycles -> if_pc/if_inst constant, no inst_req;
//    release -> next req at pc+4.
//  4 branch_flag_i=1, target=80001000 pulsed during WAIT -> current inst still
//    delivered; next inst_addr=80001000.
//  5 flush, new_pc=BFC00380 during WAIT -> stale rvalid data never on if_inst;
//    next req addr=BFC00380. Repeat with flush+branch same cycle -> BFC00380.
//  6 pc=FFFFFFFC consumed -> next inst_addr=00000000. rst asserted in WAIT ->
//    inst_req=0, if_inst=0 next cycle.

Source files
------------

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage in front of if_id.
//
// Owns the program counter and runs one req/ack/rvalid transaction at a time
// on the instruction bus. A fetched word is held on {if_pc, if_inst} until the
// pipeline consumes it (stall[0] low). stallreq_if stays high whenever no
// valid instruction is held. Taken branches from ID are remembered until the
// held instruction (the delay slot) is consumed. Exception flushes from ctrl
// redirect to new_pc and take priority over everything else.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0]          ctrl stall vector, only stall[0] (hold IF) is used
//   flush, new_pc       exception redirect
//   branch_flag_i       one-cycle taken-branch pulse from ID
//   branch_target_i     branch target, valid with branch_flag_i
//   inst_req/inst_addr  bus request and address (address stable while req)
//   inst_ack            bus accepted the address this cycle
//   inst_rvalid/rdata   bus read data return
//   if_pc/if_inst       held instruction and its PC (if_inst 0 when none)
//   stallreq_if         high while no valid instruction is held
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_addr_nxt, if_pc_nxt, if_inst_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic [31:0] npc;
  logic        inst_req_nxt, inst_valid, inst_valid_nxt;
  logic        pend_br, pend_br_nxt;
  logic        req_stale, req_stale_nxt;

  logic [4:0]  unused_stall;
  assign unused_stall = stall[5:1];

  // A branch resolved in the very cycle the delay slot is consumed has not
  // been latched yet, so it is taken straight from the ID inputs.
  function automatic logic [31:0] pick_next_pc(
    input logic        br_now,
    input logic [31:0] br_tgt,
    input logic        pend,
    input logic [31:0] pend_tgt,
    input logic [31:0] cur
  );
    if (br_now) return br_tgt;
    if (pend)   return pend_tgt;
    return cur + 32'd4;
  endfunction

  assign npc = pick_next_pc(branch_flag_i, branch_target_i, pend_br, pend_target, pc);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inst_req_nxt    = inst_req;
    inst_addr_nxt   = inst_addr;
    if_pc_nxt       = if_pc;
    if_inst_nxt     = if_inst;
    inst_valid_nxt  = inst_valid;
    pend_br_nxt     = pend_br;
    pend_target_nxt = pend_target;
    req_stale_nxt   = req_stale;

    if (flush) begin
      pc_nxt         = new_pc;
      inst_valid_nxt = 1'b0;
      if_inst_nxt    = 32'd0;
      pend_br_nxt    = 1'b0;
      unique case (state)
        IDLE, HOLD: begin
          state_nxt     = REQ;
          inst_req_nxt  = 1'b1;
          inst_addr_nxt = new_pc;
        end
        // The bus may not see a request withdrawn, so the old address stays
        // up until accepted; its data is then thrown away in DRAIN.
        REQ: begin
          if (inst_ack) begin
            inst_req_nxt  = 1'b0;
            state_nxt     = DRAIN;
            req_stale_nxt = 1'b0;
          end else begin
            req_stale_nxt = 1'b1;
          end
        end
        WAIT, DRAIN: begin
          if (inst_rvalid) begin
            state_nxt     = REQ;
            inst_req_nxt  = 1'b1;
            inst_addr_nxt = new_pc;
          end else begin
            state_nxt     = DRAIN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      if (branch_flag_i) begin
        pend_br_nxt     = 1'b1;
        pend_target_nxt = branch_target_i;
      end
      unique case (state)
        IDLE: begin
          state_nxt     = REQ;
          inst_req_nxt  = 1'b1;
          inst_addr_nxt = pc;
        end
        REQ: begin
          if (inst_ack) begin
            inst_req_nxt  = 1'b0;
            state_nxt     = req_stale ? DRAIN : WAIT;
            req_stale_nxt = 1'b0;
          end
        end
        WAIT: begin
          if (inst_rvalid) begin
            state_nxt      = HOLD;
            if_inst_nxt    = inst_rdata;
            if_pc_nxt      = pc;
            inst_valid_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (!stall[0]) begin
            pc_nxt         = npc;
            inst_valid_nxt = 1'b0;
            if_inst_nxt    = 32'd0;
            pend_br_nxt    = 1'b0;
            state_nxt      = REQ;
            inst_req_nxt   = 1'b1;
            inst_addr_nxt  = npc;
          end
        end
        DRAIN: begin
          if (inst_rvalid) begin
            state_nxt     = REQ;
            inst_req_nxt  = 1'b1;
            inst_addr_nxt = pc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- register stage: all fetch state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_req    <= 1'b0;
      inst_addr   <= RESET_PC;
      if_pc       <= RESET_PC;
      if_inst     <= 32'd0;
      inst_valid  <= 1'b0;
      pend_br     <= 1'b0;
      pend_target <= 32'd0;
      req_stale   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst_req    <= inst_req_nxt;
      inst_addr   <= inst_addr_nxt;
      if_pc       <= if_pc_nxt;
      if_inst     <= if_inst_nxt;
      inst_valid  <= inst_valid_nxt;
      pend_br     <= pend_br_nxt;
      pend_target <= pend_target_nxt;
      req_stale   <= req_stale_nxt;
    end
  end

  assign stallreq_if = ~inst_valid;

endmodule
